// File: rtl/playback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : playback_pkg
// Description : Shared encodings for the playback transport controller:
//               transport state codes and tempo select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package playback_pkg;

    // Transport state encoding (also the value driven on the state port)
    localparam logic [1:0] ST_STOP  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    // Tempo select codes; 2'b11 decodes as normal tempo
    localparam logic [1:0] SPD_NORM = 2'b00;
    localparam logic [1:0] SPD_FAST = 2'b01;
    localparam logic [1:0] SPD_SLOW = 2'b10;

endpackage
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Raw pushbutton to single-cycle press pulse. Two-flop
//               synchroniser, debouncer that accepts a new level after
//               DEBOUNCE_CYC consecutive differing samples, and a one-pulse
//               stage that fires once per accepted rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int c_cnt_w = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYC - 1);

    logic               r_sync0;
    logic               r_sync1;
    logic               r_level;
    logic               r_level_q;
    logic               r_pulse;
    logic [c_cnt_w-1:0] r_cnt;

    // Bring the asynchronous button level into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= btn_raw;
            r_sync1 <= r_sync0;
        end
    end

    // Accept a new level once it has differed from the current one for
    // DEBOUNCE_CYC samples in a row; any agreeing sample restarts the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync1 == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_level <= r_sync1;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // One pulse per accepted rising edge; re-arms only after an accepted low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_q <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_level_q <= r_level;
            r_pulse   <= r_level & ~r_level_q;
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : playback_ctrl
// Description : Transport controller. Conditions play/pause and stop
//               buttons, runs the STOP/PLAY/PAUSE state machine and
//               generates the tempo strobe and beat index for the LED sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module playback_ctrl
    import playback_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int TICK_DIV     = 25_000_000,
    parameter int BEATS        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_play,
    input  logic                     btn_stop,
    input  logic [1:0]               speed,
    output logic                     play_pause,
    output logic                     beat_tick,
    output logic [$clog2(BEATS)-1:0] beat_idx,
    output logic [1:0]               state
);

    localparam int c_cnt_w = $clog2(2 * TICK_DIV);
    localparam int c_idx_w = $clog2(BEATS);

    // Terminal counts (period minus one) so the slow period never needs
    // one more bit than the counter itself
    localparam logic [c_cnt_w-1:0] c_norm_last = c_cnt_w'(TICK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_fast_last = c_cnt_w'(TICK_DIV / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_slow_last = c_cnt_w'(2 * TICK_DIV - 1);
    localparam logic [c_idx_w-1:0] c_beat_last = c_idx_w'(BEATS - 1);

    logic               w_play_pulse;
    logic               w_stop_pulse;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_limit_m1;
    logic               w_boundary;

    logic [1:0]         r_state;
    logic               r_play_pause;
    logic               r_beat_tick;
    logic [c_idx_w-1:0] r_beat_idx;
    logic [c_cnt_w-1:0] r_cnt;

    button_conditioner #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_play (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_play),
        .pulse   (w_play_pulse)
    );

    button_conditioner #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_stop (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_stop),
        .pulse   (w_stop_pulse)
    );

    // Beat period select; the compare below is >= so shortening the period
    // mid-beat ends the beat on the next edge instead of wrapping the counter
    always_comb begin
        w_limit_m1 = c_norm_last;
        case (speed)
            SPD_NORM: w_limit_m1 = c_norm_last;
            SPD_FAST: w_limit_m1 = c_fast_last;
            SPD_SLOW: w_limit_m1 = c_slow_last;
            default:  w_limit_m1 = c_norm_last;
        endcase
    end

    assign w_boundary = (r_cnt >= w_limit_m1);

    // Transport next state; stop dominates a simultaneous play press
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop_pulse) begin
            w_state_nxt = ST_STOP;
        end else if (w_play_pulse) begin
            case (r_state)
                ST_STOP:  w_state_nxt = ST_PLAY;
                ST_PLAY:  w_state_nxt = ST_PAUSE;
                ST_PAUSE: w_state_nxt = ST_PLAY;
                default:  w_state_nxt = ST_STOP;
            endcase
        end
    end

    // State, tempo divider and beat counter; counting is gated by the
    // pre-edge state, so the edge leaving PLAY for PAUSE still counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_STOP;
            r_play_pause <= 1'b0;
            r_beat_tick  <= 1'b0;
            r_beat_idx   <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_play_pause <= (w_state_nxt == ST_PLAY);
            if (w_state_nxt == ST_STOP) begin
                r_cnt       <= '0;
                r_beat_idx  <= '0;
                r_beat_tick <= 1'b0;
            end else if (r_state == ST_PLAY) begin
                if (w_boundary) begin
                    r_cnt       <= '0;
                    r_beat_tick <= 1'b1;
                    r_beat_idx  <= (r_beat_idx == c_beat_last) ? '0 : r_beat_idx + 1'b1;
                end else begin
                    r_cnt       <= r_cnt + 1'b1;
                    r_beat_tick <= 1'b0;
                end
            end else begin
                r_beat_tick <= 1'b0;
            end
        end
    end

    assign state      = r_state;
    assign play_pause = r_play_pause;
    assign beat_tick  = r_beat_tick;
    assign beat_idx   = r_beat_idx;

endmodule
`default_nettype wire

// File: tb/tb_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_playback_ctrl
// Description : Directed self-checking bench for playback_ctrl with
//               DEBOUNCE_CYC=4, TICK_DIV=8, BEATS=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_playback_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_play;
    logic       btn_stop;
    logic [1:0] speed;
    logic       play_pause;
    logic       beat_tick;
    logic [3:0] beat_idx;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    playback_ctrl #(
        .DEBOUNCE_CYC (4),
        .TICK_DIV     (8),
        .BEATS        (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_play   (btn_play),
        .btn_stop   (btn_stop),
        .speed      (speed),
        .play_pause (play_pause),
        .beat_tick  (beat_tick),
        .beat_idx   (beat_idx),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        btn_play = 1'b0;
        btn_stop = 1'b0;
        speed    = 2'b00;
        step(3);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_pp", 32'(play_pause), 32'h0);
        chk("rst_tick", 32'(beat_tick), 32'h0);
        chk("rst_idx", 32'(beat_idx), 32'h0);
        rst = 1'b0;

        // Idle: nothing moves
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("idle_tick", 32'(beat_tick), 32'h0);
        end
        chk("idle_state", 32'(state), 32'h0);
        chk("idle_idx", 32'(beat_idx), 32'h0);

        // Hold play: PLAY appears on the 8th edge (E0+7)
        btn_play = 1'b1;
        step(7);
        chk("play_lat_early", 32'(state), 32'h0);
        step(1);
        chk("play_state", 32'(state), 32'h1);
        chk("play_pp", 32'(play_pause), 32'h1);
        chk("play_cnt0", 32'(dut.r_cnt), 32'h0);

        // 16 beats of period 8, index 1..15,0; held button must not re-toggle
        for (int k = 1; k <= 16; k++) begin
            step(7);
            chk("norm_tick_lo", 32'(beat_tick), 32'h0);
            step(1);
            chk("norm_tick_hi", 32'(beat_tick), 32'h1);
            chk("norm_idx", 32'(beat_idx), 32'(k % 16));
            chk("norm_state", 32'(state), 32'h1);
            if (k == 3) btn_play = 1'b0;
        end

        // Pause landing at cnt=3, idx=5: press so the pulse acts 40+3 edges on
        step(35);
        btn_play = 1'b1;
        step(8);
        chk("pause_state", 32'(state), 32'h2);
        chk("pause_pp", 32'(play_pause), 32'h0);
        chk("pause_cnt", 32'(dut.r_cnt), 32'h3);
        chk("pause_idx", 32'(beat_idx), 32'h5);
        btn_play = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            chk("pause_tick", 32'(beat_tick), 32'h0);
        end
        chk("pause_hold_cnt", 32'(dut.r_cnt), 32'h3);
        chk("pause_hold_idx", 32'(beat_idx), 32'h5);

        // Resume: tick 5 edges after re-entering PLAY, idx 6
        btn_play = 1'b1;
        step(8);
        chk("resume_state", 32'(state), 32'h1);
        chk("resume_cnt", 32'(dut.r_cnt), 32'h3);
        step(4);
        chk("resume_tick_lo", 32'(beat_tick), 32'h0);
        step(1);
        chk("resume_tick_hi", 32'(beat_tick), 32'h1);
        chk("resume_idx", 32'(beat_idx), 32'h6);
        btn_play = 1'b0;
        step(10);

        // Simultaneous stop and play while playing: stop wins
        btn_play = 1'b1;
        btn_stop = 1'b1;
        step(7);
        chk("both_early", 32'(state), 32'h1);
        step(1);
        chk("both_state", 32'(state), 32'h0);
        chk("both_pp", 32'(play_pause), 32'h0);
        chk("both_cnt", 32'(dut.r_cnt), 32'h0);
        chk("both_idx", 32'(beat_idx), 32'h0);
        chk("both_tick", 32'(beat_tick), 32'h0);
        btn_play = 1'b0;
        btn_stop = 1'b0;
        step(12);
        chk("stop_hold", 32'(state), 32'h0);

        // Fast tempo: period 4
        speed    = 2'b01;
        btn_play = 1'b1;
        step(8);
        chk("fast_state", 32'(state), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            step(3);
            chk("fast_tick_lo", 32'(beat_tick), 32'h0);
            step(1);
            chk("fast_tick_hi", 32'(beat_tick), 32'h1);
            chk("fast_idx", 32'(beat_idx), 32'(k));
            if (k == 1) btn_play = 1'b0;
        end

        // Slow tempo: period 16
        speed = 2'b10;
        step(15);
        chk("slow_tick_lo", 32'(beat_tick), 32'h0);
        step(1);
        chk("slow_tick_hi", 32'(beat_tick), 32'h1);
        chk("slow_idx", 32'(beat_idx), 32'h5);

        // Slow to fast with cnt=10: beat ends on the next edge
        step(10);
        chk("switch_cnt", 32'(dut.r_cnt), 32'ha);
        speed = 2'b01;
        step(1);
        chk("switch_tick", 32'(beat_tick), 32'h1);
        chk("switch_idx", 32'(beat_idx), 32'h6);
        chk("switch_cnt0", 32'(dut.r_cnt), 32'h0);
        step(3);
        chk("switch_next_lo", 32'(beat_tick), 32'h0);
        step(1);
        chk("switch_next_hi", 32'(beat_tick), 32'h1);
        chk("switch_next_idx", 32'(beat_idx), 32'h7);

        // Three-cycle glitch is rejected by the debouncer
        btn_play = 1'b1;
        step(3);
        btn_play = 1'b0;
        step(12);
        chk("glitch_state", 32'(state), 32'h1);
        chk("glitch_pp", 32'(play_pause), 32'h1);

        // Asynchronous reset mid-beat clears everything without a clock edge
        step(2);
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'h0);
        chk("arst_pp", 32'(play_pause), 32'h0);
        chk("arst_tick", 32'(beat_tick), 32'h0);
        chk("arst_idx", 32'(beat_idx), 32'h0);
        chk("arst_cnt", 32'(dut.r_cnt), 32'h0);
        step(2);
        rst = 1'b0;
        step(5);
        chk("post_rst_state", 32'(state), 32'h0);
        chk("post_rst_idx", 32'(beat_idx), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/playback_ctrl.md
# playback_ctrl

Transport controller for the LED/music playback path. It conditions the raw play/pause and stop pushbuttons and runs a STOP/PLAY/PAUSE state machine. It generates the tempo strobe and beat index that drive the LED sweep stage, and exports `play_pause` and `beat_tick`, which the LED sweep stage consumes as its enable and clock.

## Interface
- `DEBOUNCE_CYC`, 4: consecutive identical clk samples required before a button level is accepted.
- `TICK_DIV`, 25_000_000: clk cycles per beat at normal tempo (4 Hz at 100 MHz). Must be even and ≥ 2.
- `BEATS`, 16: beat count per bar; `beat_idx` wraps at `BEATS`-1.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_play`  in  1  raw play/pause pushbutton, active-high, unsynchronised.
- `btn_stop`  in  1  raw stop pushbutton, active-high, unsynchronised.
- `speed`  in  2  tempo select: 00 normal, 01 fast, 10 slow, 11 normal.
- `play_pause`  out  1  high when state is PLAY.
- `beat_tick`  out  1  one-clk-wide registered strobe, once per beat.
- `beat_idx`  out  $clog2(BEATS)  current beat, 0..BEATS-1.
- `state`  out  2  STOP=00, PLAY=01, PAUSE=10.

## Operation
- Each button passes through a 2-flop synchroniser, then a debouncer. The debouncer accepts a new level only after `DEBOUNCE_CYC` consecutive equal synchronised samples.
- A one-pulse stage then emits a single-cycle pulse on each accepted rising edge.
  - A held button yields exactly one pulse.
  - Re-arming requires an accepted low.
- State machine:
  - STOP + play pulse → PLAY.
  - PLAY + play pulse → PAUSE.
  - PAUSE + play pulse → PLAY.
  - Any state + stop pulse → STOP.
  - Stop and play pulses in the same cycle: stop wins.
- Beat period `limit`:
  - `TICK_DIV` for speed 00 or 11.
  - `TICK_DIV`/2 for speed 01.
  - `TICK_DIV`*2 for speed 10.
- Divider counter `cnt`:
  - Width $clog2(2*TICK_DIV).
  - Increments on each edge where the current state is PLAY.
  - Holds in PAUSE.
  - Forced to 0 in STOP and on any edge that enters STOP.
- Beat boundary: when `cnt` ≥ `limit`-1 in PLAY, the next edge does all of the following:
  - sets `cnt` to 0;
  - sets `beat_tick` to 1 for one cycle;
  - increments `beat_idx` modulo `BEATS`.
- The ≥ comparison covers a speed change to a shorter period mid-beat: the beat completes on the next edge rather than overrunning.
- `beat_idx` holds in PAUSE and is cleared to 0 on entering STOP.
- Resuming from PAUSE continues from the held `cnt` and `beat_idx`.

## Timing
- Reset values:
  - `state` = STOP, `play_pause` = 0, `beat_tick` = 0, `beat_idx` = 0, `cnt` = 0.
  - Synchronisers, debouncers and one-pulse history all cleared to 0.
- Reset mid-beat or mid-debounce discards all progress.
- Button latency: the raw level is high from before edge E0. The synchronised sample is valid at E0+2. `state` and `play_pause` change on edge E0+2+`DEBOUNCE_CYC`+1.
- Beat latency: `state` becomes PLAY on edge P with `cnt`=0. The first `beat_tick` is high in the cycle after edge P+`limit`, and `beat_idx`=1 from that same edge.
- The edge that moves PLAY→PAUSE still counts, because counting is gated by the pre-edge state. A pause landing on the boundary edge still produces that tick.
- `beat_tick` never asserts in STOP or PAUSE, except on the single transition edge described above.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- `playback_pkg` holds:
  - the state encoding constants `ST_STOP`, `ST_PLAY`, `ST_PAUSE`;
  - the speed codes `SPD_NORM`, `SPD_FAST`, `SPD_SLOW`.
- Sub-module `button_conditioner` (synchroniser, debouncer and one-pulse; parameter `DEBOUNCE_CYC`; ports `clk`, `rst`, `btn_raw`, `pulse`) is instantiated twice.
- The top level contains the state machine, the tempo divider and the beat counter.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4, `TICK_DIV`=8, `BEATS`=16.
- Reset, then idle 50 cycles → `state`=00, `beat_tick` never high, `beat_idx`=0.
- Hold `btn_play` 30 cycles → exactly one transition to PLAY, seen 7 edges after first sample. `beat_tick` then pulses every 8 cycles and `beat_idx` counts 1,2,…,15,0.
- Press play with `speed`=01 for 40 cycles, then set `speed`=10 → tick period 4, then 16. Switching 10→01 when `cnt`=10 gives a tick on the next edge.
- Play, then pause at `cnt`=3, `beat_idx`=5, wait 100 cycles, then play again → no ticks while paused. The next tick arrives 5 cycles after resuming and `beat_idx` becomes 6.
- Pulse stop and play in the same cycle while in PLAY → `state`=STOP, `cnt`=0, `beat_idx`=0.
- Glitch `btn_play` high for 3 cycles → no state change. Assert `rst` mid-beat → all outputs return to reset values immediately.
